// File: rtl/decoded_instr_queue.sv
// Decode-to-issue decoupling FIFO that also holds issue after a control-flow instruction until the branch resolves.
// Optional zero-latency empty-queue bypass is enabled by defining DIQ_BYPASS_EN.
package diq_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
  } scoreboard_entry_t;
endpackage

module decoded_instr_queue
  import diq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output scoreboard_entry_t          issue_instr_o,
  output logic                       issue_instr_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_ack_i,
  input  logic                       resolve_branch_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       dbg_wait_br_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_BR = 1'b1
  } state_e;

  // Handshakes: a transfer happens in a cycle where both valid and ack are high at the clock edge;
  // ack never depends combinationally on the consumer side of the same interface.
  state_e                  state_q;
  scoreboard_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0]        ctrl_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic full, empty, head_valid;
  logic push, pop, wr_en, rd_en;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_valid = !empty && (state_q == RUN);

  assign decoded_instr_ack_o = !full;
  assign count_o             = count_q;
  assign dbg_wait_br_o       = (state_q == WAIT_BR);

  assign push = decoded_instr_valid_i && !full;
  assign pop  = issue_instr_valid_o && issue_ack_i;

`ifdef DIQ_BYPASS_EN
  logic bypass;
  // An empty, running queue forwards the offered instruction straight to issue.
  assign bypass              = empty && (state_q == RUN) && decoded_instr_valid_i;
  assign issue_instr_valid_o = head_valid || bypass;
  assign issue_instr_o       = bypass ? decoded_instr_i : mem_q[rd_ptr_q];
  assign is_ctrl_flow_o      = bypass ? is_ctrl_flow_i : ctrl_q[rd_ptr_q];
  assign wr_en               = push && !(bypass && issue_ack_i);
  assign rd_en               = pop && !bypass;
`else
  assign issue_instr_valid_o = head_valid;
  assign issue_instr_o       = mem_q[rd_ptr_q];
  assign is_ctrl_flow_o      = ctrl_q[rd_ptr_q];
  assign wr_en               = push;
  assign rd_en               = pop;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      // Flush wins over any push, pop or resolve in the same cycle.
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q]  <= decoded_instr_i;
        ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      case (state_q)
        RUN:     if (pop && is_ctrl_flow_o) state_q <= WAIT_BR;
        WAIT_BR: if (resolve_branch_i) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench for decoded_instr_queue (default build): per-cycle reference model plus hand-checked scenarios.
module tb_decoded_instr_queue;
  import diq_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  scoreboard_entry_t instr_in;
  logic              vin;
  logic              cf_in;
  logic              ack_o;
  scoreboard_entry_t instr_o;
  logic              valid_o;
  logic              cf_o;
  logic              issue_ack;
  logic              resolve;
  logic [2:0]        count_o;
  logic              dbg_wait;

  logic [91:0] exp_q[$];
  logic        m_wait;
  int          errors = 0;
  int          checks = 0;
  bit          acc;

  always #5 clk = ~clk;

  decoded_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .decoded_instr_i       (instr_in),
    .decoded_instr_valid_i (vin),
    .is_ctrl_flow_i        (cf_in),
    .decoded_instr_ack_o   (ack_o),
    .issue_instr_o         (instr_o),
    .issue_instr_valid_o   (valid_o),
    .is_ctrl_flow_o        (cf_o),
    .issue_ack_i           (issue_ack),
    .resolve_branch_i      (resolve),
    .count_o               (count_o),
    .dbg_wait_br_o         (dbg_wait)
  );

  function automatic scoreboard_entry_t mk(input int n);
    scoreboard_entry_t e;
    logic [31:0] v;
    v        = n;
    e.pc     = 32'h8000_0000 + (v << 2);
    e.fu     = v[3:0];
    e.op     = v[7:0] ^ 8'h5a;
    e.rs1    = v[4:0];
    e.rs2    = ~v[4:0];
    e.rd     = v[4:0] + 5'd1;
    e.result = {v[15:0], ~v[15:0]};
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    int   n;
    logic exp_valid;
    n         = exp_q.size();
    exp_valid = (n != 0) && !m_wait;
    check("valid", 128'(valid_o), 128'(exp_valid));
    check("ack", 128'(ack_o), 128'(n != DEPTH));
    check("count", 128'(count_o), 128'(n));
    check("state", 128'(dbg_wait), 128'(m_wait));
    if (n != 0) begin
      check("head", 128'(instr_o), 128'(exp_q[0][90:0]));
      check("head_cf", 128'(cf_o), 128'(exp_q[0][91]));
    end
  endtask

  // Checks outputs mid-cycle, then advances the model by the handshakes of this cycle.
  task automatic tick(output bit accepted);
    logic [91:0] f;
    bit          do_push;
    @(negedge clk);
    check_outputs();
    accepted = 1'b0;
    if (flush) begin
      exp_q.delete();
      m_wait = 1'b0;
    end else begin
      do_push = vin && (exp_q.size() != DEPTH);
      if (exp_q.size() != 0 && !m_wait && issue_ack) begin
        f = exp_q.pop_front();
        if (f[91]) m_wait = 1'b1;
      end else if (m_wait && resolve) begin
        m_wait = 1'b0;
      end
      if (do_push) begin
        exp_q.push_back({cf_in, instr_in});
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit a;
    tick(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(valid_o), 128'(0));
    check({tag, "_cf"}, 128'(cf_o), 128'(0));
    check({tag, "_instr"}, 128'(instr_o), 128'(0));
    check({tag, "_count"}, 128'(count_o), 128'(0));
    check({tag, "_ack"}, 128'(ack_o), 128'(1));
    check({tag, "_state"}, 128'(dbg_wait), 128'(0));
  endtask

  initial begin
    int id;
    rst_n = 1'b0; flush = 1'b0; instr_in = '0; vin = 1'b0; cf_in = 1'b0;
    issue_ack = 1'b0; resolve = 1'b0; m_wait = 1'b0;
    #3;
    check_reset_outputs("reset");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill A..D with issue held off, then offer E.
    for (int i = 1; i <= 4; i++) begin
      vin = 1'b1; instr_in = mk(i); cf_in = 1'b0;
      step();
    end
    check("fill_count", 128'(count_o), 128'(4));
    check("fill_ack", 128'(ack_o), 128'(0));
    check("fill_head", 128'(instr_o), 128'(mk(1)));
    instr_in = mk(5);
    tick(acc);
    check("e_held", 128'(acc), 128'(0));

    // Streaming with issue taking every cycle; pointers wrap.
    issue_ack = 1'b1;
    id = 5;
    for (int i = 0; i < 8; i++) begin
      instr_in = mk(id);
      tick(acc);
      if (acc) id++;
    end
    check("stream_count", 128'(count_o), 128'(3));
    vin = 1'b0;
    repeat (3) step();
    check("drain_count", 128'(count_o), 128'(0));

    // Branch at head: issue blocks until resolve.
    issue_ack = 1'b0; vin = 1'b1; instr_in = mk(20); cf_in = 1'b1;
    step();
    issue_ack = 1'b1; instr_in = mk(21); cf_in = 1'b0;
    step();
    check("br_valid", 128'(valid_o), 128'(0));
    check("br_state", 128'(dbg_wait), 128'(1));
    instr_in = mk(22);
    step();
    vin = 1'b0;
    step();
    resolve = 1'b1;
    step();
    resolve = 1'b0;
    check("res_valid", 128'(valid_o), 128'(1));
    check("res_head", 128'(instr_o), 128'(mk(21)));
    repeat (2) step();
    issue_ack = 1'b0;

    // Flush a full queue with a simultaneous push, pop and resolve.
    for (int i = 30; i < 34; i++) begin
      vin = 1'b1; instr_in = mk(i);
      step();
    end
    flush = 1'b1; instr_in = mk(34); issue_ack = 1'b1; resolve = 1'b1;
    step();
    flush = 1'b0; vin = 1'b0; issue_ack = 1'b0; resolve = 1'b0;
    check("flush_count", 128'(count_o), 128'(0));
    check("flush_valid", 128'(valid_o), 128'(0));
    check("flush_ack", 128'(ack_o), 128'(1));
    check("flush_state", 128'(dbg_wait), 128'(0));
    step();

    // Empty queue: pushed entry appears one cycle later.
    vin = 1'b1; instr_in = mk(40); issue_ack = 1'b1;
    step();
    vin = 1'b0;
    check("lat_valid", 128'(valid_o), 128'(1));
    check("lat_head", 128'(instr_o), 128'(mk(40)));
    step();
    check("lat_count", 128'(count_o), 128'(0));

    // Asynchronous reset with 3 entries queued in WAIT_BR.
    issue_ack = 1'b0; vin = 1'b1; instr_in = mk(50); cf_in = 1'b1;
    step();
    issue_ack = 1'b1; instr_in = mk(51); cf_in = 1'b0;
    step();
    issue_ack = 1'b0; instr_in = mk(52);
    step();
    instr_in = mk(53);
    step();
    vin = 1'b0;
    check("pre_rst_count", 128'(count_o), 128'(3));
    check("pre_rst_state", 128'(dbg_wait), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    m_wait = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
